// File: rtl/alu_pipe_acc.sv
// alu_pipe_acc: WIDTH-bit, 16-opcode ALU with one registered output stage,
// a valid/ready handshake, an accumulator that can stand in for operand A,
// and a stored carry flag that chains ADC/SBB across multi-word operations.
module alu_pipe_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_INC  = 4'd6,
    OP_DEC  = 4'd7,
    OP_ADC  = 4'd8,
    OP_SBB  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_SAR  = 4'd12,
    OP_ROL  = 4'd13,
    OP_ROR  = 4'd14,
    OP_LOAD = 4'd15
  } aluOp_e;

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic             outValid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
  logic [WIDTH-1:0] acc_q;

  logic [WIDTH-1:0] effA;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             ovf_d;
  logic             accept;
  aluOp_e           op;

  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign effA     = use_acc ? acc_q : a;
  assign op       = aluOp_e'(alu_sel);

  // Next result, carry/borrow and signed overflow for the presented opcode;
  // arithmetic uses a WIDTH+1 bit extension so the top bit is carry or borrow.
  always_comb begin
    ext      = '0;
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    case (op)
      OP_ADD: begin
        ext      = {1'b0, effA} + {1'b0, b};
        result_d = ext[WIDTH-1:0];
        carry_d  = ext[WIDTH];
        ovf_d    = (effA[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != effA[WIDTH-1]);
      end
      OP_ADC: begin
        ext      = {1'b0, effA} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
        result_d = ext[WIDTH-1:0];
        carry_d  = ext[WIDTH];
        ovf_d    = (effA[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != effA[WIDTH-1]);
      end
      OP_INC: begin
        ext      = {1'b0, effA} + ONE_EXT;
        result_d = ext[WIDTH-1:0];
        carry_d  = ext[WIDTH];
        ovf_d    = !effA[WIDTH-1] && ext[WIDTH-1];
      end
      OP_SUB: begin
        ext      = {1'b0, effA} - {1'b0, b};
        result_d = ext[WIDTH-1:0];
        carry_d  = ext[WIDTH];
        ovf_d    = (effA[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != effA[WIDTH-1]);
      end
      OP_SBB: begin
        ext      = {1'b0, effA} - {1'b0, b} - {{WIDTH{1'b0}}, carry_q};
        result_d = ext[WIDTH-1:0];
        carry_d  = ext[WIDTH];
        ovf_d    = (effA[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != effA[WIDTH-1]);
      end
      OP_DEC: begin
        ext      = {1'b0, effA} - ONE_EXT;
        result_d = ext[WIDTH-1:0];
        carry_d  = ext[WIDTH];
        ovf_d    = effA[WIDTH-1] && !ext[WIDTH-1];
      end
      OP_AND:  result_d = effA & b;
      OP_OR:   result_d = effA | b;
      OP_XOR:  result_d = effA ^ b;
      OP_NOT:  result_d = ~effA;
      OP_SHL: begin
        result_d = {effA[WIDTH-2:0], 1'b0};
        carry_d  = effA[WIDTH-1];
      end
      OP_SHR: begin
        result_d = {1'b0, effA[WIDTH-1:1]};
        carry_d  = effA[0];
      end
      OP_SAR: begin
        result_d = {effA[WIDTH-1], effA[WIDTH-1:1]};
        carry_d  = effA[0];
      end
      OP_ROL: begin
        result_d = {effA[WIDTH-2:0], effA[WIDTH-1]};
        carry_d  = effA[WIDTH-1];
      end
      OP_ROR: begin
        result_d = {effA[0], effA[WIDTH-1:1]};
        carry_d  = effA[0];
      end
      OP_LOAD: result_d = b;
      default: result_d = '0;
    endcase
  end

  // Output stage: capture result, flags and accumulator on accept; otherwise
  // hold the data and only drop valid once the consumer has taken it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
    end else if (accept) begin
      outValid_q <= 1'b1;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= (result_d == '0);
      neg_q      <= result_d[WIDTH-1];
      ovf_q      <= ovf_d;
      acc_q      <= result_d;
    end else if (outValid_q && out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid = outValid_q;
  assign alu_out   = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// tb_alu_pipe_acc: directed scenarios followed by random operations, each
// compared against an integer-arithmetic model of the ALU and handshake.
module tb_alu_pipe_acc;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_sel;
  logic         use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         carry_out;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic [W-1:0] acc;

  int nAssert = 0;
  int nFail   = 0;

  // Reference state, in plain integers.
  int mValid, mOut, mCarry, mZero, mNeg, mOvf, mAcc;

  alu_pipe_acc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_sel(alu_sel), .use_acc(use_acc),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .carry_out(carry_out), .zero(zero), .negative(negative),
    .overflow(overflow), .acc(acc)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic int wrapW(input int t);
    return ((t % M) + M) % M;
  endfunction

  function automatic int toSigned(input int u);
    return (u >= M / 2) ? u - M : u;
  endfunction

  // Behavioural ALU: true unsigned/signed results, then range tests for flags.
  function automatic void aluModel(input int sel, input int ea, input int bb, input int cin,
                                   output int res, output int cy, output int ov);
    int sa, sb, t, st;
    sa = toSigned(ea);
    sb = toSigned(bb);
    t  = 0;
    st = 0;
    cy = 0;
    ov = 0;
    case (sel)
      0:  begin t = ea + bb;       st = sa + sb;       cy = int'(t >= M); end
      1:  begin t = ea - bb;       st = sa - sb;       cy = int'(t < 0);  end
      6:  begin t = ea + 1;        st = sa + 1;        cy = int'(t >= M); end
      7:  begin t = ea - 1;        st = sa - 1;        cy = int'(t < 0);  end
      8:  begin t = ea + bb + cin; st = sa + sb + cin; cy = int'(t >= M); end
      9:  begin t = ea - bb - cin; st = sa - sb - cin; cy = int'(t < 0);  end
      2:  t = ea & bb;
      3:  t = ea | bb;
      4:  t = ea ^ bb;
      5:  t = (M - 1) - ea;
      10: begin t = ea * 2;                            cy = ea / (M / 2); end
      11: begin t = ea / 2;                            cy = ea % 2;       end
      12: begin t = ea / 2 + ((ea >= M / 2) ? M / 2 : 0); cy = ea % 2;   end
      13: begin t = ea * 2 + ea / (M / 2);             cy = ea / (M / 2); end
      14: begin t = ea / 2 + (ea % 2) * (M / 2);       cy = ea % 2;       end
      default: t = bb;
    endcase
    if (sel inside {0, 1, 6, 7, 8, 9})
      ov = int'(st > M / 2 - 1 || st < -(M / 2));
    res = wrapW(t);
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, "_valid"}, 32'(out_valid), mValid);
    checkEq({tag, "_out"},   32'(alu_out),   mOut);
    checkEq({tag, "_carry"}, 32'(carry_out), mCarry);
    checkEq({tag, "_zero"},  32'(zero),      mZero);
    checkEq({tag, "_neg"},   32'(negative),  mNeg);
    checkEq({tag, "_ovf"},   32'(overflow),  mOvf);
    checkEq({tag, "_acc"},   32'(acc),       mAcc);
  endtask

  task automatic modelReset();
    mValid = 0; mOut = 0; mCarry = 0; mZero = 0; mNeg = 0; mOvf = 0; mAcc = 0;
  endtask

  // Drive one cycle of inputs, check in_ready before the edge, advance the
  // model across the edge and compare all registered outputs after it.
  task automatic applyStimulus(input string tag, input int v, input int sel, input int av,
                               input int bv, input int ua, input int ordy);
    int ea, res, cy, ov, expReady;
    in_valid  = v[0];
    alu_sel   = sel[3:0];
    a         = av[W-1:0];
    b         = bv[W-1:0];
    use_acc   = ua[0];
    out_ready = ordy[0];
    #1;
    expReady = int'(mValid == 0 || ordy != 0);
    checkEq({tag, "_inready"}, 32'(in_ready), expReady);
    @(posedge clk);
    if (v != 0 && expReady != 0) begin
      ea = (ua != 0) ? mAcc : av;
      aluModel(sel, ea, bv, mCarry, res, cy, ov);
      mValid = 1;
      mOut   = res;
      mCarry = cy;
      mOvf   = ov;
      mZero  = int'(res == 0);
      mNeg   = int'(res >= M / 2);
      mAcc   = res;
    end else if (mValid != 0 && ordy != 0) begin
      mValid = 0;
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    modelReset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_sel = '0;
    use_acc = 1'b0; out_ready = 1'b1;
    #12;
    checkOutput("reset");
    checkEq("reset_inready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] carry chain");
    applyStimulus("add", 1, 0, 'hF0, 'h20, 0, 1);
    checkEq("add_out_lit", 32'(alu_out), 32'h10);
    checkEq("add_carry_lit", 32'(carry_out), 32'd1);
    applyStimulus("adc", 1, 8, 'h00, 'h00, 0, 1);
    checkEq("adc_out_lit", 32'(alu_out), 32'h01);
    checkEq("adc_carry_lit", 32'(carry_out), 32'd0);

    $display("[TB] subtract family");
    applyStimulus("sub", 1, 1, 'h80, 'h01, 0, 1);
    checkEq("sub_out_lit", 32'(alu_out), 32'h7F);
    checkEq("sub_ovf_lit", 32'(overflow), 32'd1);
    applyStimulus("dec", 1, 7, 'h00, 'h00, 0, 1);
    checkEq("dec_out_lit", 32'(alu_out), 32'hFF);
    checkEq("dec_carry_lit", 32'(carry_out), 32'd1);
    checkEq("dec_neg_lit", 32'(negative), 32'd1);

    $display("[TB] accumulator chaining");
    applyStimulus("load5", 1, 15, 'h00, 'h05, 0, 1);
    checkEq("load5_out_lit", 32'(alu_out), 32'h05);
    applyStimulus("accadd", 1, 0, 'hAA, 'h03, 1, 1);
    checkEq("accadd_out_lit", 32'(alu_out), 32'h08);
    checkEq("accadd_acc_lit", 32'(acc), 32'h08);

    $display("[TB] backpressure");
    applyStimulus("drain", 0, 0, 0, 0, 0, 1);
    applyStimulus("bp_add", 1, 0, 'h01, 'h01, 0, 0);
    checkEq("bp_add_out_lit", 32'(alu_out), 32'h02);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("bp_hold", 1, 15, 'h00, 'h55, 0, 0);
      checkEq("bp_hold_acc_lit", 32'(acc), 32'h02);
    end
    applyStimulus("bp_release", 1, 15, 'h00, 'h55, 0, 1);
    checkEq("bp_release_out_lit", 32'(alu_out), 32'h55);

    $display("[TB] shifts and rotates");
    applyStimulus("sar", 1, 12, 'h81, 'h00, 0, 1);
    checkEq("sar_out_lit", 32'(alu_out), 32'hC0);
    applyStimulus("rol", 1, 13, 'h81, 'h00, 0, 1);
    checkEq("rol_out_lit", 32'(alu_out), 32'h03);
    applyStimulus("shr", 1, 11, 'h81, 'h00, 0, 1);
    checkEq("shr_out_lit", 32'(alu_out), 32'h40);
    applyStimulus("ror", 1, 14, 'h81, 'h00, 0, 1);
    checkEq("ror_out_lit", 32'(alu_out), 32'hC0);
    checkEq("ror_carry_lit", 32'(carry_out), 32'd1);

    $display("[TB] reset while stalled");
    applyStimulus("load8", 1, 15, 'h00, 'h08, 0, 1);
    applyStimulus("stall", 1, 0, 'h11, 'h22, 0, 0);
    checkEq("stall_out_lit", 32'(alu_out), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkEq("postreset_inready", 32'(in_ready), 32'd1);

    $display("[TB] random operations");
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/alu_pipe_acc.md
Name: alu_pipe_acc

Overview:
Parametrised, registered successor to the 4-bit combinational ALU. It generalises the datapath to WIDTH bits and extends the opcode set to 16 operations, adding carry-chained arithmetic, shifts, rotates and load. A single output register stage carries a valid/ready handshake, and an internal accumulator can replace operand A. Flags are registered, and the stored carry feeds ADC/SBB, so multi-word arithmetic runs through one instance.

Parameters:
WIDTH, 8, datapath width in bits (minimum 2).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation request present.
in_ready  output  1  block can accept an operation this cycle.
a  input  WIDTH  operand A (ignored when use_acc=1).
b  input  WIDTH  operand B.
alu_sel  input  4  opcode.
use_acc  input  1  1 = use accumulator as operand A.
out_valid  output  1  registered result valid.
out_ready  input  1  consumer accepts result.
alu_out  output  WIDTH  registered result.
carry_out  output  1  registered carry/borrow flag.
zero  output  1  registered, alu_out == 0.
negative  output  1  registered, alu_out[WIDTH-1].
overflow  output  1  registered signed-overflow flag.
acc  output  WIDTH  accumulator contents.

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous and active-low.
- Reset values: alu_out, carry_out, zero, negative, overflow, acc and out_valid are all 0. in_ready reads 1 immediately after reset.
- Reset mid-operation: asserting rst_n clears everything at once, whatever the handshake state. Any held result is discarded.
- Handshake: in_ready = !out_valid || out_ready (combinational).
- Accept: an operation is accepted at a rising edge when in_valid && in_ready.
- Latency: 1. On the accepting edge, the result and all four flags are registered, out_valid is set to 1, and acc is loaded with the result.
- Drain: if out_valid && out_ready and there is no new accept, out_valid clears. The data and flags hold their last values.
- Simultaneous drain and accept: the new result replaces the old one and out_valid stays 1.
- Stall: while out_valid && !out_ready:
  - alu_out and the flags hold stable;
  - in_ready = 0 and no operation is accepted;
  - acc and the stored carry do not change.
- Operand A: eff_a = use_acc ? acc : a. acc reflects the previous accepted op, so back-to-back accumulator ops chain with no bubble.
- c_in: the current carry_out register value.
- Opcodes (results truncated to WIDTH bits):
  - 0 ADD: eff_a + b.
  - 1 SUB: eff_a - b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT eff_a.
  - 6 INC: eff_a + 1.
  - 7 DEC: eff_a - 1.
  - 8 ADC: eff_a + b + c_in.
  - 9 SBB: eff_a - b - c_in.
  - 10 SHL: eff_a << 1.
  - 11 SHR: logical right shift by 1.
  - 12 SAR: arithmetic right shift by 1.
  - 13 ROL by 1.
  - 14 ROR by 1.
  - 15 LOAD: result = b.
- carry_out:
  - ADD/ADC/INC: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB/SBB/DEC: borrow, i.e. 1 when the unsigned minuend is less than subtrahend (+ c_in for SBB); DEC borrows when eff_a = 0.
  - SHL/ROL: eff_a[WIDTH-1].
  - SHR/SAR/ROR: eff_a[0].
  - Logic ops and LOAD: 0.
- overflow:
  - Add family (ADD, ADC, INC): operand signs are equal and the result sign differs.
  - Subtract family (SUB, SBB, DEC): operand signs differ and the result sign differs from eff_a.
  - All other ops: 0.
- Width boundaries: wrap-around is modulo 2^WIDTH. No saturation.
- Illegal values: none; all 16 opcodes are defined.

Test Plan:
- WIDTH=8 ADD, a=0xF0, b=0x20 -> out 0x10, carry 1, ov 0, zero 0. Then ADC, a=0x00, b=0x00 -> out 0x01, carry 0.
- SUB, a=0x80, b=0x01 -> out 0x7F, ov 1, carry 0, neg 0. Then DEC, a=0x00 -> out 0xFF, carry 1, neg 1.
- Accumulator chaining: LOAD b=0x05, then on the next cycle ADD use_acc=1, b=0x03, with out_ready=1 throughout -> outputs 0x05 then 0x08 on consecutive cycles. acc=0x08 afterwards.
- Backpressure: with out_ready=0, issue ADD 1+1 -> out_valid=1, out 0x02, in_ready=0. A second op held on in_valid is not accepted, and acc stays 0x02 for 3 cycles. Raise out_ready -> the second op is accepted on that edge.
- Shift/rotate with a=0x81:
  - SAR -> 0xC0, carry 1, neg 1.
  - ROL -> 0x03, carry 1.
  - SHR -> 0x40, carry 1.
  - ROR -> 0xC0, carry 1.
- Reset mid-stall: while stalled with out 0x08, pull rst_n low between clock edges -> out_valid, alu_out, flags and acc read 0 before the next edge. After release, in_ready=1.
